mode_ctrl: RTL

Parametrised top-level UI mode controller for the light-pen screen. It is the successor to the fixed 3-button state machine. It adds on-chip debouncing, a configurable run-mode count, a prev button, long-press-to-home on the next button, and a COLOR overlay that returns to the mode it was entered from. A configurable power-up/reset blink sequence runs before the first run mode. Its outputs drive the display/draw pipeline and the status LEDs.

---
 rtl/mode_ctrl_if.sv | 24 ++
 rtl/mode_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mode_ctrl_if.sv
// Button inputs and status outputs of the light-pen UI mode controller.
// The master side drives the raw buttons; the slave side is the controller.
interface mode_ctrl_if #(
  parameter int unsigned STATE_W = 4
);
  logic               btn_stop;
  logic               btn_next;
  logic               btn_color;
  logic               btn_prev;
  logic [STATE_W-1:0] state;
  logic [2:0]         state_deep;
  logic               blink;
  logic               mode_chg;

  modport master (
    output btn_stop, btn_next, btn_color, btn_prev,
    input  state, state_deep, blink, mode_chg
  );

  modport slave (
    input  btn_stop, btn_next, btn_color, btn_prev,
    output state, state_deep, blink, mode_chg
  );
endinterface

// File: rtl/mode_ctrl.sv
// UI mode controller: debounced buttons, reset blink sequence, N run modes,
// long-press-to-home on next, and a COLOR overlay returning to its entry mode.
module mode_ctrl #(
  parameter int unsigned CLOCK_FREQ    = 50_000_000,
  parameter int unsigned N_MODES       = 4,
  parameter int unsigned STATE_W       = 4,
  parameter int unsigned DEBOUNCE_MS   = 10,
  parameter int unsigned LONG_PRESS_MS = 800,
  parameter int unsigned BLINK_HZ      = 2,
  parameter int unsigned BLINK_COUNT   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mode_ctrl_if.slave   bus
);

  localparam int unsigned NB       = 4;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned DEEP_W   = 3;
  localparam int unsigned DEB_CYC  = CLOCK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LONG_CYC = CLOCK_FREQ / 1000 * LONG_PRESS_MS;
  localparam int unsigned HALF_CYC = CLOCK_FREQ / (2 * BLINK_HZ);

  localparam logic [CNT_W-1:0]  DEB_LAST   = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0]  LONG_LIM   = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0]  LONG_LAST  = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_CYC - 1);
  localparam logic [DEEP_W-1:0] BLINK_LAST = DEEP_W'(BLINK_COUNT - 1);

  localparam logic [STATE_W-1:0] S_RST   = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_STOP  = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_FIRST = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_LAST  = STATE_W'(N_MODES + 1);
  localparam logic [STATE_W-1:0] S_COLOR = STATE_W'(N_MODES + 2);

  localparam int unsigned B_STOP  = 0;
  localparam int unsigned B_NEXT  = 1;
  localparam int unsigned B_COLOR = 2;
  localparam int unsigned B_PREV  = 3;

  typedef enum logic [1:0] {
    PH_RST   = 2'd0,
    PH_STOP  = 2'd1,
    PH_RUN   = 2'd2,
    PH_COLOR = 2'd3
  } phase_e;

  // ---------------------------------------------------------------------------
  // Input path: synchroniser, debouncer and rise detection per button
  // ---------------------------------------------------------------------------
  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    acc;
  logic [NB-1:0]    acc_d;
  logic [CNT_W-1:0] deb_cnt [NB];
  logic [NB-1:0]    rise_c;

  assign raw = {bus.btn_prev, bus.btn_color, bus.btn_next, bus.btn_stop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      acc_d <= '0;
      for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      acc_d <= acc;
      // Any return to the accepted level restarts the stability count
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != acc[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            acc[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign rise_c = acc & ~acc_d;

  // ---------------------------------------------------------------------------
  // btn_next short/long classification
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] hold;
  logic             long_c;
  logic             next_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (!acc[B_NEXT]) begin
      hold <= '0;
    end else if (hold < LONG_LIM) begin
      hold <= hold + CNT_W'(1);
    end
  end

  // Saturating at LONG_CYC makes the long pulse single-shot and suppresses
  // the short-press pulse on the eventual release.
  assign long_c = acc[B_NEXT] && (hold == LONG_LAST);
  assign next_c = !acc[B_NEXT] && acc_d[B_NEXT] && (hold < LONG_LIM);

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  phase_e              phase_q;
  phase_e              phase_n;
  logic [STATE_W-1:0]  mode_q;      // current run mode; doubles as ret_mode in COLOR
  logic [STATE_W-1:0]  mode_n;
  logic [DEEP_W-1:0]   deep_q;
  logic [DEEP_W-1:0]   deep_n;
  logic [CNT_W-1:0]    tmr_q;
  logic [CNT_W-1:0]    tmr_n;
  logic [STATE_W-1:0]  code_n;
  logic [STATE_W-1:0]  state_q;
  logic                blink_q;
  logic                chg_q;

  always_comb begin
    phase_n = phase_q;
    mode_n  = mode_q;
    deep_n  = deep_q;
    tmr_n   = tmr_q;
    if (rise_c[B_STOP]) begin
      tmr_n   = '0;
      deep_n  = '0;
      phase_n = (phase_q == PH_STOP) ? PH_RST : PH_STOP;
    end else begin
      unique case (phase_q)
        PH_RST: begin
          if (tmr_q == HALF_LAST) begin
            tmr_n = '0;
            if (deep_q == BLINK_LAST) begin
              deep_n  = '0;
              phase_n = PH_RUN;
              mode_n  = S_FIRST;
            end else begin
              deep_n = deep_q + DEEP_W'(1);
            end
          end else begin
            tmr_n = tmr_q + CNT_W'(1);
          end
        end
        PH_STOP: begin
          phase_n = PH_STOP;
        end
        PH_RUN: begin
          if (rise_c[B_COLOR]) begin
            phase_n = PH_COLOR;
          end else if (long_c) begin
            mode_n = S_FIRST;
          end else if (next_c) begin
            mode_n = (mode_q == S_LAST) ? S_FIRST : mode_q + STATE_W'(1);
          end else if (rise_c[B_PREV]) begin
            mode_n = (mode_q == S_FIRST) ? S_LAST : mode_q - STATE_W'(1);
          end
        end
        PH_COLOR: begin
          if (rise_c[B_COLOR]) phase_n = PH_RUN;
        end
        default: begin
          phase_n = PH_RST;
          deep_n  = '0;
          tmr_n   = '0;
        end
      endcase
    end

    unique case (phase_n)
      PH_RST:   code_n = S_RST;
      PH_STOP:  code_n = S_STOP;
      PH_RUN:   code_n = mode_n;
      PH_COLOR: code_n = S_COLOR;
      default:  code_n = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_RST;
      mode_q  <= S_FIRST;
      deep_q  <= '0;
      tmr_q   <= '0;
      state_q <= S_RST;
      blink_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      phase_q <= phase_n;
      mode_q  <= mode_n;
      deep_q  <= deep_n;
      tmr_q   <= tmr_n;
      state_q <= code_n;
      blink_q <= (phase_n == PH_RST) && deep_n[0];
      chg_q   <= (code_n != state_q);
    end
  end

  assign bus.state      = state_q;
  assign bus.state_deep = deep_q;
  assign bus.blink      = blink_q;
  assign bus.mode_chg   = chg_q;

endmodule
